// File: rtl/button_reader.sv
// Debounced button reader: synchronises raw pins, debounces each one and
// queues press/release events on a valid/ready port in ascending index order.
module button_reader #(
    parameter int N_BTN      = 4,
    parameter int DB_CYCLES  = 1600000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             enable,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_state,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [3:0]       evt_idx,
    output logic             evt_press,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam int               CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES - 1);
    localparam logic [N_BTN-1:0] IDLE_RAW = {N_BTN{ACTIVE_LOW}};

    logic [N_BTN-1:0] sync_p0, sync_p1;
    logic [N_BTN-1:0] sample;
    logic [CNT_W-1:0] cnt [N_BTN];
    logic [N_BTN-1:0] toggle;
    logic [N_BTN-1:0] pend, pdir;
    logic [N_BTN-1:0] clear_mask;
    logic [3:0]       sel_idx;
    logic             sel_found;
    logic             sel_dir;
    logic             load;
    logic             take;
    logic             ovf_set;

    // Stage p0/p1: two-flop synchroniser, reset to the released raw level
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            sync_p0 <= IDLE_RAW;
            sync_p1 <= IDLE_RAW;
        end else begin
            sync_p0 <= btn_in;
            sync_p1 <= sync_p0;
        end
    end

    assign sample = ACTIVE_LOW ? ~sync_p1 : sync_p1;

    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            toggle[i] = enable && (sample[i] != btn_state[i]) && (cnt[i] == CNT_MAX);
        end
    end

    // Debounce: any disagreement-free sample or disabled reader restarts the window
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            btn_state <= '0;
            for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!enable || sample[i] == btn_state[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    cnt[i]       <= '0;
                    btn_state[i] <= ~btn_state[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Lowest-index pending button wins the output register
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_dir   = 1'b0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_found = 1'b1;
                sel_idx   = 4'(i);
                sel_dir   = pdir[i];
            end
        end
    end

    assign load       = !evt_valid || evt_ready;
    assign take       = load && sel_found;
    assign clear_mask = take ? (N_BTN'(1) << sel_idx) : '0;
    // A toggle on the button being loaded this cycle is a fresh event, not an overwrite
    assign ovf_set    = |(toggle & pend & ~clear_mask);

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            pdir     <= '0;
            overflow <= 1'b0;
        end else begin
            pend <= (pend & ~clear_mask) | toggle;
            for (int i = 0; i < N_BTN; i++) begin
                if (toggle[i]) pdir[i] <= ~btn_state[i];
            end
            if (ovf_set) overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    // Output register: holds contents stable under backpressure
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_idx   <= '0;
            evt_press <= 1'b0;
        end else if (load) begin
            evt_valid <= sel_found;
            if (sel_found) begin
                evt_idx   <= sel_idx;
                evt_press <= sel_dir;
            end
        end
    end

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with DB_CYCLES=8, four active-low buttons.
module tb_button_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] btn_in;
    logic [3:0] btn_state;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_idx;
    logic       evt_press;
    logic       overflow;
    logic       ovf_clr;

    int n_cmp  = 0;
    int n_err  = 0;
    int hs_cnt = 0;

    button_reader #(.N_BTN(4), .DB_CYCLES(8), .ACTIVE_LOW(1'b1)) dut (
        .clkin     (clk),
        .rst       (rst),
        .enable    (enable),
        .btn_in    (btn_in),
        .btn_state (btn_state),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_idx   (evt_idx),
        .evt_press (evt_press),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n edges; sample 1 time unit after each edge and count handshakes
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (evt_valid && evt_ready) hs_cnt++;
        end
    endtask

    task automatic chk_evt(input string tag, input logic v, input logic [3:0] idx, input logic p);
        chk({tag, "_valid"}, 32'(evt_valid), 32'(v));
        if (v) begin
            chk({tag, "_idx"},   32'(evt_idx),   32'(idx));
            chk({tag, "_press"}, 32'(evt_press), 32'(p));
        end
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        btn_in    = 4'hF;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;

        // Reset and idle
        tick(1);
        chk("rst_state", 32'(btn_state), 32'h0);
        chk("rst_valid", 32'(evt_valid), 32'h0);
        chk("rst_idx",   32'(evt_idx),   32'h0);
        chk("rst_press", 32'(evt_press), 32'h0);
        chk("rst_ovf",   32'(overflow),  32'h0);
        tick(4);
        rst = 1'b0;
        hs_cnt = 0;
        tick(100);
        chk("idle_state", 32'(btn_state), 32'h0);
        chk("idle_valid", 32'(evt_valid), 32'h0);
        chk("idle_events", 32'(hs_cnt), 32'h0);

        // Clean press on button 2
        btn_in[2] = 1'b0;
        tick(9);
        chk("press2_e9_state", 32'(btn_state), 32'h0);
        tick(1);
        chk("press2_e10_state", 32'(btn_state), 32'h4);
        chk("press2_e10_valid", 32'(evt_valid), 32'h0);
        tick(1);
        chk_evt("press2_e11", 1'b1, 4'd2, 1'b1);
        tick(1);
        chk("press2_e12_valid", 32'(evt_valid), 32'h0);

        btn_in[2] = 1'b1;
        tick(11);
        chk_evt("rel2_e11", 1'b1, 4'd2, 1'b0);
        tick(1);
        chk("rel2_state", 32'(btn_state), 32'h0);
        chk("rel2_drained", 32'(evt_valid), 32'h0);

        // Bounce on button 1, last transition goes low
        hs_cnt = 0;
        for (int t = 0; t < 10; t++) begin
            btn_in[1] = t[0];
            tick(3);
        end
        chk("bounce_state_mid", 32'(btn_state), 32'h0);
        btn_in[1] = 1'b0;
        tick(9);
        chk("bounce_e9_state", 32'(btn_state), 32'h0);
        tick(1);
        chk("bounce_e10_state", 32'(btn_state), 32'h2);
        tick(1);
        chk_evt("bounce_evt", 1'b1, 4'd1, 1'b1);
        tick(3);
        chk("bounce_one_event", 32'(hs_cnt), 32'h1);
        btn_in[1] = 1'b1;
        tick(13);
        chk("bounce_rel_state", 32'(btn_state), 32'h0);
        chk("bounce_rel_valid", 32'(evt_valid), 32'h0);

        // Simultaneous presses on buttons 3 and 0
        btn_in = 4'b0110;
        tick(10);
        chk("simul_state", 32'(btn_state), 32'h9);
        tick(1);
        chk_evt("simul_first", 1'b1, 4'd0, 1'b1);
        tick(1);
        chk_evt("simul_second", 1'b1, 4'd3, 1'b1);
        tick(1);
        chk("simul_drained", 32'(evt_valid), 32'h0);
        btn_in = 4'hF;
        tick(14);
        chk("simul_rel_state", 32'(btn_state), 32'h0);
        chk("simul_rel_valid", 32'(evt_valid), 32'h0);

        // Backpressure and overflow on button 1
        evt_ready = 1'b0;
        btn_in[1] = 1'b0;
        tick(11);
        chk_evt("bp_press", 1'b1, 4'd1, 1'b1);
        btn_in[1] = 1'b1;
        tick(10);
        chk("bp_rel_state", 32'(btn_state), 32'h0);
        chk("bp_rel_ovf", 32'(overflow), 32'h0);
        chk_evt("bp_hold1", 1'b1, 4'd1, 1'b1);
        btn_in[1] = 1'b0;
        tick(10);
        chk("bp_repress_state", 32'(btn_state), 32'h2);
        chk("bp_ovf_set", 32'(overflow), 32'h1);
        chk_evt("bp_hold2", 1'b1, 4'd1, 1'b1);
        evt_ready = 1'b1;
        tick(1);
        chk_evt("bp_drain2", 1'b1, 4'd1, 1'b1);
        tick(1);
        chk("bp_drained", 32'(evt_valid), 32'h0);
        chk("bp_ovf_sticky", 32'(overflow), 32'h1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("bp_ovf_clr", 32'(overflow), 32'h0);
        btn_in[1] = 1'b1;
        tick(13);
        chk("bp_rel_final", 32'(btn_state), 32'h0);
        chk("bp_rel_final_valid", 32'(evt_valid), 32'h0);

        // Enable gating on button 0
        enable = 1'b0;
        btn_in[0] = 1'b0;
        tick(50);
        chk("en_off_state", 32'(btn_state), 32'h0);
        chk("en_off_valid", 32'(evt_valid), 32'h0);
        enable = 1'b1;
        tick(7);
        chk("en_on_e7_state", 32'(btn_state), 32'h0);
        tick(1);
        chk("en_on_e8_state", 32'(btn_state), 32'h1);
        evt_ready = 1'b0;
        tick(1);
        chk_evt("en_evt", 1'b1, 4'd0, 1'b1);

        // Asynchronous reset with an event held at the output
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", 32'(btn_state), 32'h0);
        chk("arst_valid", 32'(evt_valid), 32'h0);
        chk("arst_idx",   32'(evt_idx),   32'h0);
        chk("arst_press", 32'(evt_press), 32'h0);
        chk("arst_ovf",   32'(overflow),  32'h0);
        btn_in = 4'hF;
        tick(3);
        rst = 1'b0;
        tick(20);
        chk("post_rst_valid", 32'(evt_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/button_reader.md
# button_reader

Debounced push-button/switch input reader for the fabric. It is the input-side counterpart of the LED blinker: raw board inputs go in, and clean level and event information comes out. It synchronises N asynchronous inputs into the fabric clock domain (the CCC fabric clock), debounces each one, and reports every press and release as a queued event on a valid/ready interface. Debounced levels are also output directly.

## Interface
- N_BTN, 4: number of button inputs; legal range 1..16.
- DB_CYCLES, 1600000: consecutive stable samples required to accept a level change (10 ms at 160 MHz); minimum 2.
- ACTIVE_LOW, 1: 1 means a raw input of 0 is "pressed"; 0 means a raw input of 1 is "pressed".

- clkin, in, 1: fabric clock; all logic is on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- enable, in, 1: when 0, debounce counters are held at 0 and no new level changes are accepted; pending and output events are preserved.
- btn_in, in, N_BTN: raw, asynchronous button pins.
- btn_state, out, N_BTN: debounced level; 1 means pressed.
- evt_valid, out, 1: an event is presented.
- evt_ready, in, 1: the consumer accepts the event.
- evt_idx, out, 4: button index of the presented event.
- evt_press, out, 1: 1 means press, 0 means release.
- overflow, out, 1: sticky flag; a pending event was overwritten before it was consumed.
- ovf_clr, in, 1: clears overflow.

## Operation
- **Synchroniser:** a 2-FF synchroniser per input. Both stages reset to the released raw level (1 if ACTIVE_LOW). After the second stage, the signal is normalised so that 1 means pressed.
- **Debounce** (per button i), with counter width $clog2(DB_CYCLES):
  - sample == btn_state[i], or enable=0: cnt clears to 0.
  - sample != btn_state[i] and cnt < DB_CYCLES-1: cnt increments.
  - sample != btn_state[i] and cnt == DB_CYCLES-1: btn_state[i] toggles, cnt clears, and a toggle strobe fires for one cycle.
- **Pending store:** per button, a pend bit and a pdir bit.
  - A toggle sets pend[i]=1 and pdir[i]=new btn_state[i].
  - A toggle while pend[i] is already 1 overwrites pdir[i] and sets overflow.
- **Output register:** loads when evt_valid=0, or when evt_valid=1 and evt_ready=1.
  - It takes the lowest-index set pend bit, sets evt_idx/evt_press from it, and clears that pend bit.
  - If no pend bit is set, evt_valid goes to 0.
  - While evt_valid=1 and evt_ready=0, evt_idx and evt_press are held stable.
- **Simultaneous toggle and load on the same button:** the new toggle stays pending with its new direction. The loaded (older) event goes to the output. No overflow is raised.
- **Simultaneous toggles on several buttons:** all are pended and drained in ascending index order.
- **ovf_clr:** clears overflow. If ovf_clr coincides with a new overflow condition, set wins.
- **Reset mid-operation:** all counters, pending bits and the output register clear immediately. In-flight events are discarded.

## Timing
- **Reset values:** btn_state=0, evt_valid=0, evt_idx=0, evt_press=0, overflow=0, all cnt=0, all pend=0.
- **Level latency:** a clean input change is sampled at edge 1 and btn_state changes at edge DB_CYCLES+2.
- **Event latency:** evt_valid rises one edge after the btn_state change (edge DB_CYCLES+3), provided the output register was empty.
- **Throughput:** one event per clock while evt_ready=1.
- **Back-to-back transfer:** an accepted event followed by a pending event leaves evt_valid at 1 with new contents on the next edge.
- **Bounce:** any sample equal to the current btn_state restarts the full DB_CYCLES window.
- **Enable:** deasserting enable aborts any partial count. A count resumes from 0 after enable returns to 1.

## Test plan
1. **Reset and idle:** apply rst=1 for 5 cycles, then release, with btn_in=4'hF (ACTIVE_LOW=1) held for 100 cycles → all outputs 0 and no evt_valid.
2. **Clean press:** with DB_CYCLES=8, drive btn_in[2] 1→0 → btn_state[2]=1 at edge 10; evt_valid=1, evt_idx=2, evt_press=1 at edge 11; with evt_ready=1, evt_valid=0 at edge 12.
3. **Bounce:** with DB_CYCLES=8, toggle btn_in[1] every 3 cycles for 30 cycles, then hold it low → exactly one press event for idx 1; btn_state[1] rises 10 edges after the last transition.
4. **Simultaneous presses:** press buttons 3 and 0 on the same cycle with evt_ready=1 → idx 0 press, then idx 3 press on consecutive cycles.
5. **Backpressure and overflow:** with evt_ready=0, press button 1, release it, then press it again, each after debounce → output holds idx1 press and overflow=1. With evt_ready=1 → receive idx1 press, then idx1 press (the release is lost). Pulsing ovf_clr → overflow=0.
6. **Enable and reset abort:**
   - Press button 0 with enable=0 for 50 cycles → btn_state unchanged; raise enable → btn_state[0]=1 after 8 more edges.
   - Assert rst with an event held at the output → everything returns to 0 immediately.
